// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch and data access.
// Define MEM_ARB_TIMEOUT_EN to abort accesses that are not acked within TIMEOUT_CYCLES cycles.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StFetch, StData} stateT;

  stateT state;
  logic  fetchPri;
  logic  pulseOut;
  logic  grantData;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must fit the 8-bit timeout counter (1..255)");
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] toCnt;
  logic       toErr;
  assign timeout_err = toErr;
`else
  assign timeout_err = 1'b0;
`endif

  assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

  // No grant while a completion pulse is out: the owner's req is still high that cycle.
  assign pulseOut  = if_valid | d_valid;
  assign grantData = d_req & ~(if_req & fetchPri);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      fetchPri  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      toCnt     <= '0;
      toErr     <= 1'b0;
`endif
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        StIdle: begin
          if (!pulseOut) begin
            if (grantData) begin
              state     <= StData;
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else if (if_req) begin
              state    <= StFetch;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          toCnt <= '0;
`endif
        end
        StFetch: begin
          if (mem_ack) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            fetchPri <= 1'b0;
            mem_req  <= 1'b0;
            state    <= StIdle;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (toCnt == TimeoutLast) begin
            if_rdata <= '0;
            if_valid <= 1'b1;
            fetchPri <= 1'b0;
            mem_req  <= 1'b0;
            toErr    <= 1'b1;
            toCnt    <= '0;
            state    <= StIdle;
          end else begin
            toCnt <= toCnt + 8'd1;
          end
`endif
        end
        StData: begin
          if (mem_ack) begin
            if (!mem_we) d_rdata <= mem_rdata;
            d_valid  <= 1'b1;
            fetchPri <= 1'b1;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            state    <= StIdle;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (toCnt == TimeoutLast) begin
            d_rdata  <= '0;
            d_valid  <= 1'b1;
            fetchPri <= 1'b1;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            toErr    <= 1'b1;
            toCnt    <= '0;
            state    <= StIdle;
          end else begin
            toCnt <= toCnt + 8'd1;
          end
`endif
        end
        default: begin
          state   <= StIdle;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
